super_alu: RTL and testbench



---
 rtl/super_alu.sv | 77 +++++++
 tb/tb_super_alu.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/super_alu.sv
// Registered 32-bit execute-stage ALU: integer ops plus pixel-average and threshold.
// Result and {N,Z,C,V} flags are captured on every rising clock edge.
module super_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Control,
    output logic [3:0]  Flags,
    output logic [31:0] Result
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_PIX  = 3'b101;
    localparam logic [2:0] OP_UMB  = 3'b110;

    logic [32:0] add_full;
    logic [32:0] sub_full;
    logic [31:0] mul_lo;
    logic [9:0]  pix_sum;
    logic [19:0] pix_prod;

    logic [31:0] result_d, result_q;
    logic [3:0]  flags_d, flags_q;
    logic        carry_d, ovf_d;

    always_comb begin
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} + {1'b0, ~B} + 33'd1;
        mul_lo   = A * B;
        pix_sum  = {2'b00, A[23:16]} + {2'b00, A[15:8]} + {2'b00, A[7:0]};
        // 683/2048 slightly exceeds 1/3; the error stays below 1/8 for sums up to 765, so the floor is exact
        pix_prod = {10'd0, pix_sum} * 20'd683;

        result_d = 32'd0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (Control)
            OP_ADD: begin
                result_d = add_full[31:0];
                carry_d  = add_full[32];
                ovf_d    = (A[31] == B[31]) && (add_full[31] != A[31]);
            end
            OP_SUB: begin
                result_d = sub_full[31:0];
                carry_d  = sub_full[32];
                ovf_d    = (A[31] != B[31]) && (sub_full[31] != A[31]);
            end
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_MUL:  result_d = mul_lo;
            OP_PIX:  result_d = {12'd0, pix_prod} >> 11;
            OP_UMB:  result_d = (A >= B) ? 32'd255 : 32'd0;
            default: result_d = 32'd0;
        endcase

        flags_d = {result_d[31], (result_d == 32'd0), carry_d, ovf_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign Result = result_q;
    assign Flags  = flags_q;

endmodule

// File: tb/tb_super_alu.sv
// Scoreboard bench for super_alu: drivers push expected {Result, Flags} into a queue,
// a monitor pops and compares one edge later.
module tb_super_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [2:0]  ctl = 3'b000;
    logic [3:0]  flags;
    logic [31:0] result;

    logic [35:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;

    super_alu dut (
        .clk(clk),
        .rst(rst),
        .A(a),
        .B(b),
        .Control(ctl),
        .Flags(flags),
        .Result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                     name, act[35:4], act[3:0], exp[35:4], exp[3:0]);
        end
    endtask

    task automatic drive(input string name, input logic [2:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        ctl = c;
        a   = x;
        b   = y;
        exp_q.push_back({er, ef});
        name_q.push_back(name);
    endtask

    // Monitor: one expected entry is due after each edge following a drive
    initial begin
        logic [35:0] e;
        string       n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {result, flags}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // asynchronous reset from power-up
        ctl = 3'b000; a = 32'd3; b = 32'd4;
        #1 rst = 1'b1;
        #1 check("reset_async", {result, flags}, 36'd0);
        @(posedge clk);
        #1 check("reset_hold", {result, flags}, 36'd0);
        #1 rst = 1'b0;
        drive("rst_release_add", 3'b000, 32'd1, 32'd14, 32'd15, 4'b0000);

        drive("add_1_15",      3'b000, 32'd1,          32'd15, 32'd16,         4'b0000);
        drive("add_0_0",       3'b000, 32'd0,          32'd0,  32'd0,          4'b0100);
        drive("add_carry",     3'b000, 32'hFFFF_FFFF,  32'd1,  32'd0,          4'b0110);
        drive("add_ovf",       3'b000, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  4'b1001);
        drive("sub_2_1",       3'b001, 32'd2,          32'd1,  32'd1,          4'b0010);
        drive("sub_borrow",    3'b001, 32'd0,          32'd13, 32'hFFFF_FFF3,  4'b1000);
        drive("sub_7_2",       3'b001, 32'd7,          32'd2,  32'd5,          4'b0010);
        drive("sub_equal",     3'b001, 32'd5,          32'd5,  32'd0,          4'b0110);
        drive("sub_ovf",       3'b001, 32'h8000_0000,  32'd1,  32'h7FFF_FFFF,  4'b0011);
        drive("and_4_2",       3'b010, 32'd4,          32'd2,  32'd0,          4'b0100);
        drive("and_6_2",       3'b010, 32'd6,          32'd2,  32'd2,          4'b0000);
        drive("or_1_14",       3'b011, 32'd1,          32'd14, 32'd15,         4'b0000);
        drive("or_9_5",        3'b011, 32'd9,          32'd5,  32'd13,         4'b0000);
        drive("or_7_4",        3'b011, 32'd7,          32'd4,  32'd7,          4'b0000);
        drive("or_3_3",        3'b011, 32'd3,          32'd3,  32'd3,          4'b0000);
        drive("mul_10_10",     3'b100, 32'd10,         32'd10, 32'd100,        4'b0000);
        drive("mul_1_1",       3'b100, 32'd1,          32'd1,  32'd1,          4'b0000);
        drive("mul_7_5",       3'b100, 32'd7,          32'd5,  32'd35,         4'b0000);
        drive("mul_20_7",      3'b100, 32'd20,         32'd7,  32'd140,        4'b0000);
        drive("mul_wrap",      3'b100, 32'h0001_0000,  32'h0001_0000, 32'd0,   4'b0100);
        drive("mul_ff_ff",     3'b100, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,   4'b0000);
        drive("pix_0a0a0a",    3'b101, 32'h000A_0A0A,  32'd99, 32'd10,         4'b0000);
        drive("pix_0a0500",    3'b101, 32'h000A_0500,  32'd0,  32'd5,          4'b0000);
        drive("pix_505003",    3'b101, 32'h0050_5003,  32'd7,  32'd54,         4'b0000);
        drive("pix_0a0908",    3'b101, 32'h000A_0908,  32'd1,  32'd9,          4'b0000);
        drive("pix_ffffffff",  3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd255, 4'b0000);
        drive("pix_floor_2",   3'b101, 32'h0000_0002,  32'd0,  32'd0,          4'b0100);
        drive("pix_764",       3'b101, 32'h00FF_FFFE,  32'd0,  32'd254,        4'b0000);
        drive("umb_10_10",     3'b110, 32'd10,         32'd10, 32'd255,        4'b0000);
        drive("umb_1_10",      3'b110, 32'd1,          32'd10, 32'd0,          4'b0100);
        drive("umb_7_5",       3'b110, 32'd7,          32'd5,  32'd255,        4'b0000);
        drive("umb_4_5",       3'b110, 32'd4,          32'd5,  32'd0,          4'b0100);
        drive("umb_max_0",     3'b110, 32'hFFFF_FFFF,  32'd0,  32'd255,        4'b0000);
        drive("reserved",      3'b111, 32'd5,          32'd7,  32'd0,          4'b0100);
        drive("after_rsvd",    3'b000, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'hFFFF_FFFE, 4'b1001);
        drive("pre_reset_umb", 3'b110, 32'd9,          32'd3,  32'd255,        4'b0000);

        // mid-cycle reset discards the pending ADD
        @(negedge clk);
        ctl = 3'b000; a = 32'd5; b = 32'd5;
        #2 rst = 1'b1;
        #1 check("reset_mid_async", {result, flags}, 36'd0);
        @(posedge clk);
        #1 check("reset_mid_hold", {result, flags}, 36'd0);
        #1 rst = 1'b0;
        drive("post_reset_sub", 3'b001, 32'd0,  32'd1,  32'hFFFF_FFFF, 4'b1000);
        drive("post_reset_or",  3'b011, 32'hF0, 32'h0F, 32'hFF,        4'b0000);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
